csar_pc_sequencer: RTL and testbench
====================================

// Module: csar_pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the cosine-similarity control store (CSAR).
//  Extends the plain enabled PC register with start/halt control, stall, jumps, conditional
//  branches, one hardware loop (vector-length iteration) and a small call/return stack.
//  Sits between the CroC memory-mapped start register and the control-store ROM: pc addresses
//  the ROM, and the decoded op/target/cond of the current word feed back the same cycle.
// PARAMETERS
//  W        4  PC width; control store holds 2**W words
//  LOOP_W   8  hardware-loop counter width
//  STACK_D  2  return-stack depth (>=1)
//  RESET_PC 0  PC value on reset and on start
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       asynchronous reset, active-high
//  start     in   1       1-cycle pulse from CroC mem-mapped reg; honoured in IDLE and DONE only
//  stall     in   1       freeze all state in RUN (datapath not ready)
//  op        in   3       opcode of word at pc: 0 NEXT,1 JMP,2 BRC,3 LOOP,4 ENDL,5 CALL,6 RET,7 HALT
//  target    in   W       jump/branch/call target of word at pc
//  loop_cnt  in   LOOP_W  iteration count for LOOP
//  cond      in   1       branch condition for BRC
//  pc        out  W       current PC (registered)
//  busy      out  1       1 in RUN
//  done      out  1       1 in DONE; held until next start
//  err       out  1       sticky error flag; cleared by start
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, busy=done=err=0, sp=0, loop inactive, lcnt=0.
//  FSM IDLE -> RUN on start (pc<=RESET_PC, err<=0, sp<=0, loop cleared); DONE -> RUN on start, same.
//  RUN -> DONE on HALT (pc holds) or on any error (err<=1). start in RUN is ignored.
//  In RUN with stall=1: pc, sp, stack, loop regs and state hold; op ignored.
//  In RUN with stall=0, one op retires per cycle; pc updates next edge (latency 1):
//   NEXT: pc+1.  JMP: target.  BRC: cond ? target : pc+1.
//   LOOP: lstart<=pc+1, lcnt<=max(loop_cnt,1), loop active, pc+1. LOOP while active -> error.
//   ENDL: if lcnt>1: lcnt-1, pc<=lstart; else loop inactive, lcnt<=0, pc+1.
//         ENDL with no active loop -> error. loop_cnt=0 runs body once (same as 1).
//   CALL: push pc+1, sp+1, pc<=target. sp==STACK_D -> error (overflow), no push.
//   RET: pc<=top, sp-1. sp==0 -> error (underflow).  HALT: -> DONE.
//  Arithmetic: pc+1 modulo 2**W (wraps 2**W-1 -> 0, no error); lstart likewise.
//  Error: pc holds the faulting op's address, state DONE, done=1, err=1.
//  Outputs are registered; busy = (state==RUN), done = (state==DONE).
//  Loop state is independent of the stack: CALL/RET inside a loop is legal; one loop level only.
//  rst asserted mid-RUN: all state returns to reset values immediately; no done pulse.
// TESTING
//  1 rst, start pulse, ops NEXT,NEXT,HALT at pc 0,1,2 -> pc 0,1,2; busy 1 for 3 cycles; done=1, pc=2.
//  2 LOOP loop_cnt=3 at pc1, ENDL at pc3 -> pc seq 1,2,3,2,3,2,3,4; loop_cnt=0 -> 1,2,3,4.
//  3 CALL target=8 at pc2, RET at pc9 -> pc 2,8,9,3; STACK_D=2 triple nested CALL -> err=1, done=1.
//  4 stall held 4 cycles mid-loop -> pc and lcnt unchanged; resumes exact sequence; start in RUN ignored.
//  5 W=4, NEXT at pc 15 -> pc 0, err 0; BRC cond=0 -> pc+1, cond=1 -> target; ENDL w/o LOOP -> err.
//  6 rst pulse between edges in RUN -> pc=RESET_PC, busy=0 asynchronously; later start runs cleanly.

Source files
------------

// File: rtl/csar_pc_sequencer.sv
// -----------------------------------------------------------------------------
// csar_pc_sequencer
//
// Program-counter sequencer for the cosine-similarity control store. The PC
// addresses the control-store ROM. The decoded op/target/loop_cnt/cond of the
// word at that address return in the same cycle, and one op retires per
// unstalled cycle while running. Besides plain increment it supports:
// start/halt, stall, jumps, conditional branches, one hardware loop, and a
// small call/return stack.
//
// Parameters
//   W        PC width; the control store holds 2**W words
//   LOOP_W   hardware-loop counter width
//   STACK_D  return-stack depth (>= 1)
//   RESET_PC PC value on reset and on start
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   start     in   1-cycle start pulse; honoured in IDLE and DONE only
//   stall     in   freezes all state while running
//   op        in   opcode of the word at pc
//                  (NEXT, JMP, BRC, LOOP, ENDL, CALL, RET, HALT)
//   target    in   jump/branch/call target of the word at pc
//   loop_cnt  in   iteration count for LOOP (0 behaves as 1)
//   cond      in   branch condition for BRC
//   pc        out  current PC
//   busy      out  1 while running
//   done      out  1 after HALT or an error, held until the next start
//   err       out  sticky error flag, cleared by start
// -----------------------------------------------------------------------------
module csar_pc_sequencer #(
  parameter int W        = 4,
  parameter int LOOP_W   = 8,
  parameter int STACK_D  = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  input  logic [2:0]        op,
  input  logic [W-1:0]      target,
  input  logic [LOOP_W-1:0] loop_cnt,
  input  logic              cond,
  output logic [W-1:0]      pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Stack pointer counts occupied entries, 0..STACK_D inclusive.
  localparam int SP_W = $clog2(STACK_D + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRC  = 3'd2;
  localparam logic [2:0] OP_LOOP = 3'd3;
  localparam logic [2:0] OP_ENDL = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [W-1:0]    PC_INIT = W'(RESET_PC);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_D);

  logic [1:0]        state_q,  state_d;
  logic [W-1:0]      pc_q,     pc_d;
  logic [SP_W-1:0]   sp_q,     sp_d;
  logic              lact_q,   lact_d;
  logic [LOOP_W-1:0] lcnt_q,   lcnt_d;
  logic [W-1:0]      lstart_q, lstart_d;
  logic              err_q,    err_d;

  logic              push_en;
  logic              fault;
  logic [W-1:0]      pc_inc;
  logic [SP_W-1:0]   top_idx;

  // Sized to the pointer's full range so any sp value indexes legally.
  logic [W-1:0]      stack_q [2**SP_W];

  // Wraps modulo 2**W by construction; running off the top is not an error.
  assign pc_inc  = pc_q + W'(1);
  assign top_idx = sp_q - SP_W'(1);

  always_comb begin
    // NOTE: every combinational output gets a default before the case
    // statements so that no path leaves it unassigned (no inferred latches).
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    lact_d   = lact_q;
    lcnt_d   = lcnt_q;
    lstart_d = lstart_q;
    err_d    = err_q;
    push_en  = 1'b0;
    fault    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = PC_INIT;
          err_d   = 1'b0;
          sp_d    = '0;
          lact_d  = 1'b0;
          lcnt_d  = '0;
        end
      end

      S_RUN: begin
        if (!stall) begin
          unique case (op)
            OP_NEXT: pc_d = pc_inc;
            OP_JMP:  pc_d = target;
            OP_BRC:  pc_d = cond ? target : pc_inc;
            OP_LOOP: begin
              // Only one loop level exists; nesting is a program error.
              if (lact_q) begin
                fault = 1'b1;
              end else begin
                lstart_d = pc_inc;
                lcnt_d   = (loop_cnt == '0) ? LOOP_W'(1) : loop_cnt;
                lact_d   = 1'b1;
                pc_d     = pc_inc;
              end
            end
            OP_ENDL: begin
              if (!lact_q) begin
                fault = 1'b1;
              end else if (lcnt_q > LOOP_W'(1)) begin
                lcnt_d = lcnt_q - LOOP_W'(1);
                pc_d   = lstart_q;
              end else begin
                lact_d = 1'b0;
                lcnt_d = '0;
                pc_d   = pc_inc;
              end
            end
            OP_CALL: begin
              if (sp_q == SP_FULL) begin
                fault = 1'b1;
              end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                pc_d    = target;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                fault = 1'b1;
              end else begin
                pc_d = stack_q[top_idx];
                sp_d = top_idx;
              end
            end
            OP_HALT: state_d = S_DONE;
            default: pc_d = pc_q;
          endcase

          // A faulting op leaves pc on its own address for post-mortem.
          if (fault) begin
            state_d = S_DONE;
            pc_d    = pc_q;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_INIT;
      sp_q     <= '0;
      lact_q   <= 1'b0;
      lcnt_q   <= '0;
      lstart_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      lact_q   <= lact_d;
      lcnt_q   <= lcnt_d;
      lstart_q <= lstart_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the return stack has no reset. sp gates every read, so stale
  // entries are never observed, and leaving out the reset keeps it a plain
  // register file.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_q[sp_q] <= pc_inc;
    end
  end

  assign pc   = pc_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_csar_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csar_pc_sequencer
//
// Self-checking bench for csar_pc_sequencer (W=4, LOOP_W=8, STACK_D=2,
// RESET_PC=0). The bench holds a small ROM, indexed by the model's PC, that
// supplies op/target/loop_cnt/cond. The reference model tracks the run flag,
// PC, a queue-based return stack and loop bookkeeping. Each cycle's
// {pc,busy,done,err} is compared against that model. The executed-PC traces
// of the directed programs are also compared against hand-written literals.
// -----------------------------------------------------------------------------
module tb_csar_pc_sequencer;

  localparam int W        = 4;
  localparam int LOOP_W   = 8;
  localparam int STACK_D  = 2;
  localparam int RESET_PC = 0;
  localparam int DEPTH    = 2**W;

  localparam int NEXT = 0, JMP = 1, BRC = 2, LOOP = 3;
  localparam int ENDL = 4, CALL = 5, RET = 6, HALT = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stall;
  logic [2:0]        op;
  logic [W-1:0]      target;
  logic [LOOP_W-1:0] loop_cnt;
  logic              cond;
  logic [W-1:0]      pc;
  logic              busy;
  logic              done;
  logic              err;

  csar_pc_sequencer #(
    .W(W), .LOOP_W(LOOP_W), .STACK_D(STACK_D), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .op(op),
    .target(target), .loop_cnt(loop_cnt), .cond(cond),
    .pc(pc), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Control-store image
  int rom_op   [DEPTH];
  int rom_tgt  [DEPTH];
  int rom_lc   [DEPTH];
  int rom_cond [DEPTH];
  bit rand_cond = 0;

  // Reference model
  bit m_run, m_done, m_err, m_lact;
  int m_pc, m_lcnt, m_lstart;
  int m_stack[$];
  string trace;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_trace(input string name, input string exp);
    n_vec++;
    if (trace != exp) begin
      n_fail++;
      $display("FAIL %s: pc trace got '%s' expected '%s'", name, trace, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_err = 0; m_pc = RESET_PC;
    m_stack.delete(); m_lact = 0; m_lcnt = 0; m_lstart = 0;
  endtask

  task automatic model_step(input bit st, input bit stl, input int o,
                            input int tg, input int lc, input bit c);
    bit fault, halt;
    int nxt;
    fault = 0; halt = 0;
    nxt = (m_pc + 1) % DEPTH;
    if (!m_run) begin
      if (st) begin
        model_reset();
        m_run = 1;
      end
    end else if (!stl) begin
      case (o)
        NEXT: m_pc = nxt;
        JMP:  m_pc = tg;
        BRC:  m_pc = c ? tg : nxt;
        LOOP: if (m_lact) fault = 1;
              else begin
                m_lstart = nxt; m_lcnt = (lc == 0) ? 1 : lc;
                m_lact = 1; m_pc = nxt;
              end
        ENDL: if (!m_lact) fault = 1;
              else if (m_lcnt > 1) begin m_lcnt--; m_pc = m_lstart; end
              else begin m_lact = 0; m_lcnt = 0; m_pc = nxt; end
        CALL: if (m_stack.size() == STACK_D) fault = 1;
              else begin m_stack.push_back(nxt); m_pc = tg; end
        RET:  if (m_stack.size() == 0) fault = 1;
              else m_pc = m_stack.pop_back();
        default: halt = 1;
      endcase
      if (fault || halt) begin
        m_run = 0; m_done = 1;
        if (fault) m_err = 1;
      end
    end
  endtask

  // One clock: compare at the falling edge, drive, then retire on the rising edge.
  task automatic cycle(input bit st, input bit stl);
    logic [31:0] exp_v;
    int o, tg, lc;
    bit c;
    @(negedge clk);
    exp_v = {25'd0, W'(m_pc), m_run, m_done, m_err};
    check("cycle", {25'd0, pc, busy, done, err}, exp_v);
    o  = rom_op[m_pc];
    tg = rom_tgt[m_pc];
    lc = rom_lc[m_pc];
    c  = rand_cond ? 1'($urandom_range(0, 1)) : rom_cond[m_pc][0];
    if (m_run && !stl) trace = {trace, $sformatf("%0d,", m_pc)};
    start = st; stall = stl;
    op = 3'(o); target = W'(tg); loop_cnt = LOOP_W'(lc); cond = c;
    @(posedge clk);
    model_step(st, stl, o, tg, lc, c);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) begin
      rom_op[i] = HALT; rom_tgt[i] = 0; rom_lc[i] = 0; rom_cond[i] = 0;
    end
  endtask

  task automatic set_word(input int a, input int o, input int tg,
                          input int lc, input int c);
    rom_op[a] = o; rom_tgt[a] = tg; rom_lc[a] = lc; rom_cond[a] = c;
  endtask

  // Start the program and clock until the model reaches DONE, within a budget.
  task automatic run_prog(input string name, input int budget);
    trace = "";
    cycle(1, 0);
    for (int n = 0; n < budget && m_run; n++) cycle(0, 0);
    check({name, "_timeout"}, 32'(m_run), 32'd0);
    cycle(0, 0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    check("async_rst_pc", 32'(pc), 32'(RESET_PC));
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stall = 0; op = 0; target = 0; loop_cnt = 0; cond = 0;
    model_reset();
    clear_rom();
    #12;
    check("reset_state", {28'd0, pc}, 32'(RESET_PC));
    check("reset_flags", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b0;

    // 1: NEXT, NEXT, HALT
    set_word(0, NEXT, 0, 0, 0); set_word(1, NEXT, 0, 0, 0); set_word(2, HALT, 0, 0, 0);
    run_prog("t1", 20);
    check_trace("t1_trace", "0,1,2,");
    check("t1_done_pc", {28'd0, pc}, 32'd2);
    check("t1_flags", {29'd0, busy, done, err}, 32'b010);

    // 2: LOOP x3 over pc 2..3, then loop_cnt=0 runs the body once
    clear_rom();
    set_word(0, NEXT, 0, 0, 0); set_word(1, LOOP, 0, 3, 0);
    set_word(2, NEXT, 0, 0, 0); set_word(3, ENDL, 0, 0, 0); set_word(4, HALT, 0, 0, 0);
    run_prog("t2a", 40);
    check_trace("t2a_trace", "0,1,2,3,2,3,2,3,4,");
    rom_lc[1] = 0;
    run_prog("t2b", 40);
    check_trace("t2b_trace", "0,1,2,3,4,");

    // 3: CALL/RET, then stack overflow on the third nested CALL
    clear_rom();
    set_word(0, NEXT, 0, 0, 0); set_word(1, NEXT, 0, 0, 0); set_word(2, CALL, 8, 0, 0);
    set_word(3, HALT, 0, 0, 0); set_word(8, NEXT, 0, 0, 0); set_word(9, RET, 0, 0, 0);
    run_prog("t3a", 40);
    check_trace("t3a_trace", "0,1,2,8,9,3,");
    check("t3a_err", 32'(err), 32'd0);
    clear_rom();
    set_word(0, CALL, 4, 0, 0); set_word(4, CALL, 8, 0, 0); set_word(8, CALL, 12, 0, 0);
    run_prog("t3b", 40);
    check_trace("t3b_trace", "0,4,8,");
    check("t3b_flags", {28'd0, pc, done, err}, {26'd0, 4'd8, 2'b11});

    // 4: stall 4 cycles mid-loop with a start pulse inside; sequence resumes
    clear_rom();
    set_word(0, NEXT, 0, 0, 0); set_word(1, LOOP, 0, 3, 0);
    set_word(2, NEXT, 0, 0, 0); set_word(3, ENDL, 0, 0, 0); set_word(4, HALT, 0, 0, 0);
    trace = "";
    cycle(1, 0);
    for (int n = 0; n < 4; n++) cycle(0, 0);
    for (int n = 0; n < 4; n++) cycle(n == 1, 1);
    cycle(1, 0);
    for (int n = 0; n < 40 && m_run; n++) cycle(0, 0);
    cycle(0, 0);
    check_trace("t4_trace", "0,1,2,3,2,3,2,3,4,");

    // 5: wrap at pc 15, BRC both ways, ENDL with no loop
    clear_rom();
    set_word(0, JMP, 15, 0, 0); set_word(15, NEXT, 0, 0, 0);
    trace = "";
    cycle(1, 0);
    cycle(0, 0);
    set_word(0, BRC, 9, 0, 0); set_word(1, BRC, 6, 0, 1); set_word(6, ENDL, 0, 0, 0);
    for (int n = 0; n < 20 && m_run; n++) cycle(0, 0);
    cycle(0, 0);
    check_trace("t5_trace", "0,15,0,1,6,");
    check("t5_flags", {28'd0, pc, done, err}, {26'd0, 4'd6, 2'b11});

    // 6: asynchronous reset mid-run, then a clean restart
    clear_rom();
    set_word(0, NEXT, 0, 0, 0); set_word(1, NEXT, 0, 0, 0); set_word(2, NEXT, 0, 0, 0);
    set_word(3, HALT, 0, 0, 0);
    cycle(1, 0); cycle(0, 0); cycle(0, 0);
    mid_reset();
    cycle(0, 0);
    run_prog("t6", 20);
    check_trace("t6_trace", "0,1,2,3,");

    // Randomized programs against the model
    rand_cond = 1;
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int r;
        r = $urandom_range(0, 15);
        rom_op[i]  = (r < 6 || r > 13) ? NEXT :
                     (r == 6) ? JMP : (r < 9) ? BRC : (r == 9) ? LOOP :
                     (r == 10) ? ENDL : (r == 11) ? CALL : (r == 12) ? RET : HALT;
        rom_tgt[i] = $urandom_range(0, DEPTH - 1);
        rom_lc[i]  = $urandom_range(0, 3);
      end
      cycle(1, 0);
      for (int n = 0; n < 60; n++) begin
        cycle($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
        if ($urandom_range(0, 99) == 0) mid_reset();
      end
    end
    cycle(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
